// File: rtl/pipeline_ctrl.sv
// Pipeline control: memory-wait FSM, post-redirect flush window, load-use and PPU-send hazards.
// Define PIPELINE_CTRL_TIMEOUT_EN to bound WAIT and emit a one-cycle mem_timeout abort.
//
// state | meaning
// IDLE  | no outstanding memory access
// WAIT  | access in flight, pipeline frozen until mem_ack
// ABORT | timeout build only: one-cycle abort pulse to MEM, then IDLE

module pipeline_ctrl #(
   parameter int FLUSH_CYCLES   = 2,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [4:0] read_register1_if_id,
   input  logic [4:0] read_register2_if_id,
   input  logic       rd_en_ex,
   input  logic [4:0] write_reg_ex,
   input  logic       branch_taken_ex,
   input  logic       mem_req,
   input  logic       mem_ack,
   input  logic       ppu_send,
   input  logic       ppu_ready,
   output logic       hazard,
   output logic       flush,
   output logic       stall_mem,
   output logic       ppu_valid,
   output logic       mem_timeout
);

   if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 7) begin : g_bad_flush
      $error("pipeline_ctrl: FLUSH_CYCLES must be 1..7");
   end
   if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
      $error("pipeline_ctrl: TIMEOUT_CYCLES must be 2..255");
   end

   localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

`ifdef PIPELINE_CTRL_TIMEOUT_EN
   typedef enum logic [1:0] {
      MEM_IDLE  = 2'd0,
      MEM_WAIT  = 2'd1,
      MEM_ABORT = 2'd2
   } mem_state_e;

   // The request cycle in IDLE already stalls, so WAIT itself lasts TIMEOUT_CYCLES-1 cycles.
   localparam logic [7:0] WAIT_LOAD = 8'(TIMEOUT_CYCLES - 2);

   logic [7:0] wait_tmr_q, wait_tmr_d;
`else
   typedef enum logic {
      MEM_IDLE = 1'b0,
      MEM_WAIT = 1'b1
   } mem_state_e;
`endif

   mem_state_e state_q, state_d;
   logic [2:0] flush_cnt_q, flush_cnt_d;
   logic       load_use;
   logic       ppu_wait;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= MEM_IDLE;
         flush_cnt_q <= 3'd0;
      end else begin
         state_q     <= state_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

`ifdef PIPELINE_CTRL_TIMEOUT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_tmr_q <= 8'd0;
      end else begin
         wait_tmr_q <= wait_tmr_d;
      end
   end
`endif

   always_comb begin
      state_d     = state_q;
      stall_mem   = 1'b0;
      mem_timeout = 1'b0;
`ifdef PIPELINE_CTRL_TIMEOUT_EN
      wait_tmr_d  = wait_tmr_q;
`endif
      case (state_q)
         MEM_IDLE: begin
            if (mem_req && !mem_ack) begin
               stall_mem = 1'b1;
               state_d   = MEM_WAIT;
`ifdef PIPELINE_CTRL_TIMEOUT_EN
               wait_tmr_d = WAIT_LOAD;
`endif
            end
         end
         MEM_WAIT: begin
            if (mem_ack) begin
               state_d = MEM_IDLE;
            end else begin
               stall_mem = 1'b1;
`ifdef PIPELINE_CTRL_TIMEOUT_EN
               if (wait_tmr_q == 8'd0) begin
                  state_d = MEM_ABORT;
               end else begin
                  wait_tmr_d = wait_tmr_q - 8'd1;
               end
`endif
            end
         end
`ifdef PIPELINE_CTRL_TIMEOUT_EN
         MEM_ABORT: begin
            mem_timeout = 1'b1;
            state_d     = MEM_IDLE;
         end
`endif
         default: begin
            state_d = MEM_IDLE;
         end
      endcase
   end

   // A redirect seen while stalled keeps flush high but only loads once EX can advance.
   always_comb begin
      flush_cnt_d = flush_cnt_q;
      if (!stall_mem) begin
         if (branch_taken_ex) begin
            flush_cnt_d = FLUSH_LOAD;
         end else if (flush_cnt_q != 3'd0) begin
            flush_cnt_d = flush_cnt_q - 3'd1;
         end
      end
   end

   always_comb begin
      flush    = branch_taken_ex | (flush_cnt_q != 3'd0);
      load_use = rd_en_ex & (write_reg_ex != 5'd0) &
                 ((write_reg_ex == read_register1_if_id) |
                  (write_reg_ex == read_register2_if_id));
      ppu_wait  = ppu_send & ~ppu_ready;
      hazard    = ~stall_mem & ~flush & (load_use | ppu_wait);
      ppu_valid = ppu_send & ppu_ready & ~stall_mem & ~flush & ~load_use;
   end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios plus randomized traffic
// compared cycle by cycle against a behavioural model of the control rules.

module tb_pipeline_ctrl;

   localparam int FC = 2;
   localparam int TO = 8;
`ifdef PIPELINE_CTRL_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic [4:0] rs1 = '0, rs2 = '0, wr = '0;
   logic       rd_en = 1'b0, br = 1'b0, req = 1'b0, ack = 1'b0, send = 1'b0, ready = 1'b0;
   logic       hazard, flush, stall_mem, ppu_valid, mem_timeout;
   logic [4:0] dut_out;
   logic [4:0] exp_v;

   int n_checks = 0;
   int n_pass   = 0;

   // model state: stall cycles in the current access, abort pending, flush cycles still owed
   int m_stalls = 0;
   bit m_abort  = 1'b0;
   int m_flush_left = 0;

   always #5 clk = ~clk;

   pipeline_ctrl #(.FLUSH_CYCLES(FC), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst_n(rst_n),
      .read_register1_if_id(rs1), .read_register2_if_id(rs2),
      .rd_en_ex(rd_en), .write_reg_ex(wr), .branch_taken_ex(br),
      .mem_req(req), .mem_ack(ack), .ppu_send(send), .ppu_ready(ready),
      .hazard(hazard), .flush(flush), .stall_mem(stall_mem),
      .ppu_valid(ppu_valid), .mem_timeout(mem_timeout)
   );

   assign dut_out = {stall_mem, flush, hazard, ppu_valid, mem_timeout};

   function automatic bit model_stall();
      return !m_abort && !ack && (m_stalls > 0 || req);
   endfunction

   function automatic logic [4:0] model_out();
      bit s, f, lu, h, v;
      s  = model_stall();
      f  = br || (m_flush_left > 0);
      lu = rd_en && (wr != 0) && (wr == rs1 || wr == rs2);
      h  = !s && !f && (lu || (send && !ready));
      v  = send && ready && !s && !f && !lu;
      return {s, f, h, v, m_abort};
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_stalls     <= 0;
         m_abort      <= 1'b0;
         m_flush_left <= 0;
      end else begin
         if (m_abort) begin
            m_abort  <= 1'b0;
            m_stalls <= 0;
         end else if (model_stall()) begin
            if (TO_EN && (m_stalls + 1 == TO)) begin
               m_abort  <= 1'b1;
               m_stalls <= 0;
            end else begin
               m_stalls <= m_stalls + 1;
            end
         end else begin
            m_stalls <= 0;
         end
         if (!model_stall()) begin
            if (br) m_flush_left <= FC - 1;
            else if (m_flush_left > 0) m_flush_left <= m_flush_left - 1;
         end
      end
   end

   task automatic clear_inputs();
      rs1 = '0; rs2 = '0; wr = '0; rd_en = 0; br = 0; req = 0; ack = 0; send = 0; ready = 0;
   endtask

   task automatic test_reset();
      #1 rst_n = 1'b0;
      #1;
      n_checks++; if (dut_out !== 5'b00000) $display("FAIL reset_async: got %b want 00000", dut_out); else n_pass++;
      @(negedge clk); #1;
      n_checks++; if (dut_out !== 5'b00000) $display("FAIL reset_held: got %b want 00000", dut_out); else n_pass++;
      @(negedge clk); rst_n = 1'b1; #1;
      n_checks++; if (dut_out !== 5'b00000) $display("FAIL reset_release: got %b want 00000", dut_out); else n_pass++;
   endtask

   task automatic test_load_use();
      @(negedge clk); rd_en = 1; wr = 5'd5; rs2 = 5'd5; rs1 = 5'd0; #1;
      n_checks++; if (dut_out !== 5'b00100) $display("FAIL lu_rs2: got %b want 00100", dut_out); else n_pass++;
      @(negedge clk); rd_en = 0; #1;
      n_checks++; if (dut_out !== 5'b00000) $display("FAIL lu_bubble: got %b want 00000", dut_out); else n_pass++;
      @(negedge clk); rd_en = 1; wr = 5'd0; rs1 = 5'd0; rs2 = 5'd0; #1;
      n_checks++; if (dut_out !== 5'b00000) $display("FAIL lu_x0: got %b want 00000", dut_out); else n_pass++;
      @(negedge clk); wr = 5'd7; rs1 = 5'd7; rs2 = 5'd3; #1;
      n_checks++; if (dut_out !== 5'b00100) $display("FAIL lu_rs1: got %b want 00100", dut_out); else n_pass++;
      @(negedge clk); clear_inputs();
   endtask

   task automatic test_redirect();
      @(negedge clk); br = 1; #1;
      n_checks++; if (dut_out !== 5'b01000) $display("FAIL redir_c0: got %b want 01000", dut_out); else n_pass++;
      @(negedge clk); br = 0; #1;
      n_checks++; if (dut_out !== 5'b01000) $display("FAIL redir_c1: got %b want 01000", dut_out); else n_pass++;
      @(negedge clk); #1;
      n_checks++; if (dut_out !== 5'b00000) $display("FAIL redir_end: got %b want 00000", dut_out); else n_pass++;
      // stall during the second flush cycle
      @(negedge clk); br = 1; #1;
      n_checks++; if (dut_out !== 5'b01000) $display("FAIL redir2_c0: got %b want 01000", dut_out); else n_pass++;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); br = 0; req = 1; #1;
         n_checks++; if (dut_out !== 5'b11000) $display("FAIL redir2_stall%0d: got %b want 11000", i, dut_out); else n_pass++;
      end
      @(negedge clk); ack = 1; #1;
      n_checks++; if (dut_out !== 5'b01000) $display("FAIL redir2_unstall: got %b want 01000", dut_out); else n_pass++;
      @(negedge clk); req = 0; ack = 0; #1;
      n_checks++; if (dut_out !== 5'b00000) $display("FAIL redir2_drop: got %b want 00000", dut_out); else n_pass++;
      // redirect arriving while stalled loads only once unstalled
      @(negedge clk); req = 1; br = 1; #1;
      n_checks++; if (dut_out !== 5'b11000) $display("FAIL redir3_stall_a: got %b want 11000", dut_out); else n_pass++;
      @(negedge clk); #1;
      n_checks++; if (dut_out !== 5'b11000) $display("FAIL redir3_stall_b: got %b want 11000", dut_out); else n_pass++;
      @(negedge clk); ack = 1; #1;
      n_checks++; if (dut_out !== 5'b01000) $display("FAIL redir3_load: got %b want 01000", dut_out); else n_pass++;
      @(negedge clk); req = 0; ack = 0; br = 0; #1;
      n_checks++; if (dut_out !== 5'b01000) $display("FAIL redir3_tail: got %b want 01000", dut_out); else n_pass++;
      @(negedge clk); #1;
      n_checks++; if (dut_out !== 5'b00000) $display("FAIL redir3_end: got %b want 00000", dut_out); else n_pass++;
   endtask

   task automatic test_mem_wait();
      for (int i = 1; i <= 3; i++) begin
         @(negedge clk); req = 1; #1;
         n_checks++; if (dut_out !== 5'b10000) $display("FAIL mw_stall%0d: got %b want 10000", i, dut_out); else n_pass++;
      end
      @(negedge clk); ack = 1; #1;
      n_checks++; if (dut_out !== 5'b00000) $display("FAIL mw_ack: got %b want 00000", dut_out); else n_pass++;
      @(negedge clk); req = 0; ack = 0; #1;
      n_checks++; if (dut_out !== 5'b00000) $display("FAIL mw_idle: got %b want 00000", dut_out); else n_pass++;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); req = 1; ack = 1; #1;
         n_checks++; if (dut_out !== 5'b00000) $display("FAIL mw_same_cycle%0d: got %b want 00000", i, dut_out); else n_pass++;
      end
      @(negedge clk); ack = 0; #1;
      n_checks++; if (dut_out !== 5'b10000) $display("FAIL mw_reissue: got %b want 10000", dut_out); else n_pass++;
      @(negedge clk); ack = 1; #1;
      @(negedge clk); clear_inputs();
   endtask

   task automatic test_timeout();
      int stalls;
      bit saw_to;
`ifdef PIPELINE_CTRL_TIMEOUT_EN
      stalls = 0;
      @(negedge clk); req = 1; #1;
      while (stall_mem === 1'b1 && stalls < 40) begin
         stalls++;
         @(negedge clk); #1;
      end
      n_checks++; if (stalls != TO) $display("FAIL to_stall_len: got %0d want %0d", stalls, TO); else n_pass++;
      n_checks++; if (dut_out !== 5'b00001) $display("FAIL to_abort: got %b want 00001", dut_out); else n_pass++;
      @(negedge clk); req = 0; #1;
      n_checks++; if (dut_out !== 5'b00000) $display("FAIL to_idle: got %b want 00000", dut_out); else n_pass++;
      // ack in the ABORT cycle is ignored
      for (int i = 0; i < TO; i++) begin
         @(negedge clk); req = 1; #1;
      end
      @(negedge clk); ack = 1; #1;
      n_checks++; if (dut_out !== 5'b00001) $display("FAIL to_ack_ignored: got %b want 00001", dut_out); else n_pass++;
      @(negedge clk); req = 0; ack = 0; #1;
      n_checks++; if (dut_out !== 5'b00000) $display("FAIL to_idle2: got %b want 00000", dut_out); else n_pass++;
      // ack on the last allowed stall cycle avoids the abort
      for (int i = 0; i < TO - 1; i++) begin
         @(negedge clk); req = 1; #1;
      end
      @(negedge clk); ack = 1; #1;
      n_checks++; if (dut_out !== 5'b00000) $display("FAIL to_edge_ack: got %b want 00000", dut_out); else n_pass++;
      @(negedge clk); req = 0; ack = 0; #1;
      n_checks++; if (dut_out !== 5'b00000) $display("FAIL to_edge_no_abort: got %b want 00000", dut_out); else n_pass++;
`else
      stalls = 0;
      saw_to = 1'b0;
      for (int i = 0; i < 110; i++) begin
         @(negedge clk); req = 1; #1;
         if (stall_mem === 1'b1) stalls++;
         if (mem_timeout !== 1'b0) saw_to = 1'b1;
      end
      n_checks++; if (stalls != 110) $display("FAIL nto_stall_len: got %0d want 110", stalls); else n_pass++;
      n_checks++; if (saw_to !== 1'b0) $display("FAIL nto_no_timeout: got %b want 0", saw_to); else n_pass++;
      @(negedge clk); ack = 1; #1;
      n_checks++; if (dut_out !== 5'b00000) $display("FAIL nto_release: got %b want 00000", dut_out); else n_pass++;
      @(negedge clk); req = 0; ack = 0; #1;
      n_checks++; if (dut_out !== 5'b00000) $display("FAIL nto_idle: got %b want 00000", dut_out); else n_pass++;
`endif
   endtask

   task automatic test_ppu();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); send = 1; ready = 0; #1;
         n_checks++; if (dut_out !== 5'b00100) $display("FAIL ppu_wait%0d: got %b want 00100", i, dut_out); else n_pass++;
      end
      @(negedge clk); ready = 1; #1;
      n_checks++; if (dut_out !== 5'b00010) $display("FAIL ppu_strobe: got %b want 00010", dut_out); else n_pass++;
      @(negedge clk); send = 0; ready = 0; #1;
      n_checks++; if (dut_out !== 5'b00000) $display("FAIL ppu_done: got %b want 00000", dut_out); else n_pass++;
      @(negedge clk); send = 1; ready = 1; br = 1; #1;
      n_checks++; if (dut_out !== 5'b01000) $display("FAIL ppu_flush: got %b want 01000", dut_out); else n_pass++;
      @(negedge clk); br = 0; #1;
      n_checks++; if (dut_out !== 5'b01000) $display("FAIL ppu_flush_tail: got %b want 01000", dut_out); else n_pass++;
      @(negedge clk); #1;
      n_checks++; if (dut_out !== 5'b00010) $display("FAIL ppu_after_flush: got %b want 00010", dut_out); else n_pass++;
      @(negedge clk); rd_en = 1; wr = 5'd4; rs1 = 5'd4; #1;
      n_checks++; if (dut_out !== 5'b00100) $display("FAIL ppu_load_use: got %b want 00100", dut_out); else n_pass++;
      @(negedge clk); clear_inputs();
   endtask

   task automatic test_reset_mid_wait();
      for (int i = 1; i <= 5; i++) begin
         @(negedge clk); req = 1; #1;
      end
      n_checks++; if (dut_out !== 5'b10000) $display("FAIL rst_pre_wait: got %b want 10000", dut_out); else n_pass++;
      #2 rst_n = 0; req = 0;
      #1;
      n_checks++; if (dut_out !== 5'b00000) $display("FAIL rst_mid_wait: got %b want 00000", dut_out); else n_pass++;
      @(negedge clk); rst_n = 1; #1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); #1;
         n_checks++; if (dut_out !== 5'b00000) $display("FAIL rst_after%0d: got %b want 00000", i, dut_out); else n_pass++;
      end
      @(negedge clk); br = 1; #1;
      @(negedge clk); br = 0; #1;
      n_checks++; if (dut_out !== 5'b01000) $display("FAIL rst_pre_flush: got %b want 01000", dut_out); else n_pass++;
      #2 rst_n = 0;
      #1;
      n_checks++; if (dut_out !== 5'b00000) $display("FAIL rst_mid_flush: got %b want 00000", dut_out); else n_pass++;
      @(negedge clk); rst_n = 1; #1;
      n_checks++; if (dut_out !== 5'b00000) $display("FAIL rst_flush_release: got %b want 00000", dut_out); else n_pass++;
   endtask

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         rs1   = 5'($urandom_range(0, 3));
         rs2   = 5'($urandom_range(0, 3));
         wr    = 5'($urandom_range(0, 3));
         rd_en = ($urandom_range(0, 1) == 1);
         br    = ($urandom_range(0, 9) == 0);
         req   = ($urandom_range(0, 9) < 4);
         ack   = ($urandom_range(0, 9) < 3);
         send  = ($urandom_range(0, 9) < 3);
         ready = ($urandom_range(0, 1) == 1);
         #1;
         exp_v = model_out();
         n_checks++;
         if (dut_out !== exp_v)
            $display("FAIL rand_cycle%0d: got %b want %b (stall,flush,hazard,valid,timeout)", i, dut_out, exp_v);
         else
            n_pass++;
      end
      @(negedge clk); clear_inputs();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("%0d/%0d checks passed", n_pass, n_checks + 1);
      $fatal(1);
   end

   initial begin
      clear_inputs();
      test_reset();
      test_load_use();
      test_redirect();
      test_mem_wait();
      test_timeout();
      test_ppu();
      test_reset_mid_wait();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
